// File: rtl/game_tick_scheduler_pkg.sv
// Shared run-state encoding, default divisors and move-period helper for the snake game timing blocks.
// Pure declarations: no latency, no flow control.
package game_tick_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_OVER    = 2'd3
  } run_state_t;

  localparam int unsigned DEF_SEC_DIV         = 25000000;
  localparam int unsigned DEF_BASE_MOVE_DIV   = 6250000;
  localparam int unsigned DEF_STEP_DIV        = 625000;
  localparam int unsigned DEF_MIN_MOVE_DIV    = 1562500;
  localparam int unsigned DEF_MAX_LEVEL       = 7;
  localparam int unsigned DEF_SCORE_PER_LEVEL = 5;

  // Compare before subtracting so a deep level never wraps the period.
  function automatic int unsigned calc_move_period(input int unsigned lvl,
                                                   input int unsigned base_div,
                                                   input int unsigned step_div,
                                                   input int unsigned min_div);
    int unsigned cut;
    cut = lvl * step_div;
    if (cut >= base_div - min_div) return min_div;
    return base_div - cut;
  endfunction

endpackage

// File: rtl/game_tick_scheduler_tick.sv
// Divider that emits a registered one-cycle strobe every `period` enabled cycles.
// Latency: strobe registered; hold via enable=0, clear forces count and strobe to 0.
module tick_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock_25,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH:0]   period,
  output logic             tick
);

  logic [WIDTH-1:0] count;
  logic [WIDTH:0]   last;

  assign last = period - (WIDTH+1)'(1);

  // >= lets a shortened period fire right away instead of overrunning.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (enable) begin
      if ({1'b0, count} >= last) begin
        count <= '0;
        tick  <= 1'b1;
      end else begin
        count <= count + WIDTH'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Snake game timing: run-state FSM, move/second strobes, mm:ss game clock and speed level.
// Latency: all outputs registered; inputs are pulses/levels with no backpressure.
module game_tick_scheduler
  import game_tick_scheduler_pkg::*;
#(
  parameter int unsigned SEC_DIV         = DEF_SEC_DIV,
  parameter int unsigned BASE_MOVE_DIV   = DEF_BASE_MOVE_DIV,
  parameter int unsigned STEP_DIV        = DEF_STEP_DIV,
  parameter int unsigned MIN_MOVE_DIV    = DEF_MIN_MOVE_DIV,
  parameter int unsigned MAX_LEVEL       = DEF_MAX_LEVEL,
  parameter int unsigned SCORE_PER_LEVEL = DEF_SCORE_PER_LEVEL
) (
  input  logic       clock_25,
  input  logic       reset,
  input  logic       start,
  input  logic       pause_btn,
  input  logic       game_over,
  input  logic       score_inc,
  output logic       move_tick,
  output logic       sec_tick,
  output logic [5:0] seconds,
  output logic [6:0] minutes,
  output logic [2:0] level,
  output logic [1:0] run_state
);

  localparam int MOVE_W  = $clog2(BASE_MOVE_DIV);
  localparam int SEC_W   = $clog2(SEC_DIV);
  localparam int SCORE_W = (SCORE_PER_LEVEL > 1) ? $clog2(SCORE_PER_LEVEL) : 1;
  localparam logic [SEC_W:0] SEC_PERIOD = (SEC_W+1)'(SEC_DIV);

  run_state_t           state;
  logic [SCORE_W-1:0]   score_cnt;
  logic [MOVE_W:0]      move_period;
  logic                 entering;
  logic                 run_en;
  logic                 score_ok;
  logic                 cnt_clear;

  assign run_state   = state;
  assign move_period = (MOVE_W+1)'(calc_move_period(32'(level), BASE_MOVE_DIV,
                                                    STEP_DIV, MIN_MOVE_DIV));

  // Counters advance only on cycles that stay in RUNNING, so no strobe leaks past a pause or game over.
  assign entering  = (state == ST_IDLE) && start;
  assign run_en    = (state == ST_RUNNING) && start && !game_over && !pause_btn;
  assign score_ok  = (state == ST_RUNNING) && start && !game_over && score_inc;
  assign cnt_clear = (state == ST_IDLE);

  tick_counter #(.WIDTH(MOVE_W)) u_move (
    .clock_25 (clock_25),
    .reset    (reset),
    .enable   (run_en),
    .clear    (cnt_clear),
    .period   (move_period),
    .tick     (move_tick)
  );

  tick_counter #(.WIDTH(SEC_W)) u_sec (
    .clock_25 (clock_25),
    .reset    (reset),
    .enable   (run_en),
    .clear    (cnt_clear),
    .period   (SEC_PERIOD),
    .tick     (sec_tick)
  );

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      seconds   <= '0;
      minutes   <= '0;
      level     <= '0;
      score_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:    if (start) state <= ST_RUNNING;
        ST_RUNNING: begin
          if (!start)         state <= ST_IDLE;
          else if (game_over) state <= ST_OVER;
          else if (pause_btn) state <= ST_PAUSED;
        end
        ST_PAUSED: begin
          if (!start)         state <= ST_IDLE;
          else if (game_over) state <= ST_OVER;
          else if (pause_btn) state <= ST_RUNNING;
        end
        ST_OVER:    if (!start) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase

      if (entering) begin
        seconds   <= '0;
        minutes   <= '0;
        level     <= '0;
        score_cnt <= '0;
      end else begin
        if (sec_tick) begin
          if (seconds == 6'd59) begin
            seconds <= '0;
            if (minutes != 7'd99) minutes <= minutes + 7'd1;
          end else begin
            seconds <= seconds + 6'd1;
          end
        end
        if (score_ok) begin
          if (score_cnt == SCORE_W'(SCORE_PER_LEVEL - 1)) begin
            score_cnt <= '0;
            if (level != 3'(MAX_LEVEL)) level <= level + 3'd1;
          end else begin
            score_cnt <= score_cnt + SCORE_W'(1);
          end
        end
      end
    end
  end

endmodule
